// File: rtl/mod_divide_if.sv
// Handshake bundle for the half-precision divider.
// master drives the operands and the start strobe; slave returns the quotient
// and a one-cycle ready pulse.
//   in_A, in_B : dividend / divisor words
//   in_En      : start strobe, taken only while the divider is idle
//   out_Out    : quotient, held until the next result
//   out_Ready  : one-cycle pulse when out_Out carries a new result
interface mod_divide_if #(
    parameter int unsigned WORD_W = 16
);
    logic [WORD_W-1:0] in_A;
    logic [WORD_W-1:0] in_B;
    logic              in_En;
    logic [WORD_W-1:0] out_Out;
    logic              out_Ready;

    modport master (
        output in_A,
        output in_B,
        output in_En,
        input  out_Out,
        input  out_Ready
    );

    modport slave (
        input  in_A,
        input  in_B,
        input  in_En,
        output out_Out,
        output out_Ready
    );
endinterface

// File: rtl/mod_divide.sv
// Sequential IEEE-754 binary16 divider: out_Out = in_A / in_B.
// Radix-2 restoring mantissa division with a fixed 15-edge latency from the
// in_En capture edge to the out_Ready cycle, special cases included.
// Subnormal inputs are read as zero and subnormal results flush to zero.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : mod_divide_if slave (in_A, in_B, in_En, out_Out, out_Ready)
module mod_divide #(
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned FRAC_W = 10,
    parameter int unsigned BIAS   = 15
) (
    input  logic        clk,
    input  logic        rst,
    mod_divide_if.slave bus
);

    localparam int unsigned WORD_W = 1 + EXP_W + FRAC_W;
    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned Q_W    = FRAC_W + 2;
    localparam int unsigned E_W    = EXP_W + 2;
    localparam int unsigned CNT_W  = $clog2(Q_W);

    localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(Q_W - 1);
    localparam logic [EXP_W-1:0]      EXP_ONES  = '1;
    localparam logic signed [E_W-1:0] E_OVF     = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_ZERO    = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_ROUND,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } special_t;

    state_t                  state_q;
    logic [WORD_W-1:0]       a_q;
    logic [WORD_W-1:0]       b_q;
    logic                    sign_q;
    logic [MANT_W-1:0]       mb_q;
    logic [Q_W-1:0]          rem_q;
    logic [Q_W-1:0]          quo_q;
    logic signed [E_W-1:0]   exp_q;
    special_t                special_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    round_step_q;
    logic [FRAC_W-1:0]       frac_q;
    logic [WORD_W-1:0]       out_q;
    logic                    ready_q;

    // Operand field views of the latched words
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [FRAC_W-1:0] frac_a;
    logic [FRAC_W-1:0] frac_b;

    assign exp_a  = a_q[WORD_W-2 -: EXP_W];
    assign exp_b  = b_q[WORD_W-2 -: EXP_W];
    assign frac_a = a_q[FRAC_W-1:0];
    assign frac_b = b_q[FRAC_W-1:0];

    // Unpack: hidden bits, pre-normalising shift, biased exponent, special decode
    logic [MANT_W-1:0]     mant_a;
    logic [MANT_W-1:0]     mant_b;
    logic                  pre_shift;
    logic [Q_W-1:0]        rem_init;
    logic signed [E_W-1:0] exp_init;
    logic                  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    special_t              special_init;

    always_comb begin
        mant_a       = {1'b1, frac_a};
        mant_b       = {1'b1, frac_b};
        pre_shift    = mant_a < mant_b;
        rem_init     = pre_shift ? {mant_a, 1'b0} : {1'b0, mant_a};
        exp_init     = E_W'(exp_a) - E_W'(exp_b) + E_W'(BIAS) - E_W'(pre_shift);
        nan_a        = (exp_a == EXP_ONES) && (frac_a != '0);
        nan_b        = (exp_b == EXP_ONES) && (frac_b != '0);
        inf_a        = (exp_a == EXP_ONES) && (frac_a == '0);
        inf_b        = (exp_b == EXP_ONES) && (frac_b == '0);
        zero_a       = (exp_a == '0);
        zero_b       = (exp_b == '0);
        special_init = SP_NONE;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            special_init = SP_NAN;
        end else if (inf_a || zero_b) begin
            special_init = SP_INF;
        end else if (zero_a || inf_b) begin
            special_init = SP_ZERO;
        end
    end

    // One restoring step: subtract when the partial remainder covers the divisor
    logic           rem_ge;
    logic [Q_W-1:0] rem_sub;
    logic [Q_W-1:0] rem_next;
    logic [Q_W-1:0] quo_next;

    always_comb begin
        rem_ge   = rem_q >= {1'b0, mb_q};
        rem_sub  = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_next = rem_sub << 1;
        quo_next = Q_W'({quo_q, rem_ge});
    end

    // Round to nearest even; quo_q[0] is the guard bit, leftover remainder is sticky.
    // A carry out of the fraction means the mantissa reached 2.0.
    logic              round_up;
    logic [FRAC_W:0]   frac_sum;
    logic              frac_carry;

    always_comb begin
        round_up   = quo_q[0] & ((|rem_q) | quo_q[1]);
        frac_sum   = {1'b0, quo_q[FRAC_W:1]} + (FRAC_W+1)'(round_up);
        frac_carry = frac_sum[FRAC_W];
    end

    // Final word: special-case override, then exponent range limits
    logic [WORD_W-1:0] result_c;

    always_comb begin
        result_c = '0;
        case (special_q)
            SP_NAN:  result_c = {1'b0, EXP_ONES, 1'b1, (FRAC_W-1)'(0)};
            SP_INF:  result_c = {sign_q, EXP_ONES, FRAC_W'(0)};
            SP_ZERO: result_c = {sign_q, (WORD_W-1)'(0)};
            default: begin
                if (exp_q >= E_OVF) begin
                    result_c = {sign_q, EXP_ONES, FRAC_W'(0)};
                end else if (exp_q <= E_ZERO) begin
                    result_c = {sign_q, (WORD_W-1)'(0)};
                end else begin
                    result_c = {sign_q, exp_q[EXP_W-1:0], frac_q};
                end
            end
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sign_q       <= 1'b0;
            mb_q         <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            exp_q        <= '0;
            special_q    <= SP_NONE;
            cnt_q        <= '0;
            round_step_q <= 1'b0;
            frac_q       <= '0;
            out_q        <= '0;
            ready_q      <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_En) begin
                        a_q     <= bus.in_A;
                        b_q     <= bus.in_B;
                        state_q <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_q    <= a_q[WORD_W-1] ^ b_q[WORD_W-1];
                    mb_q      <= mant_b;
                    rem_q     <= rem_init;
                    quo_q     <= '0;
                    exp_q     <= exp_init;
                    special_q <= special_init;
                    cnt_q     <= '0;
                    state_q   <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (cnt_q == LAST_ITER) begin
                        cnt_q        <= '0;
                        round_step_q <= 1'b0;
                        state_q      <= S_ROUND;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ROUND: begin
                    // First cycle applies the increment, second packs the word
                    if (!round_step_q) begin
                        frac_q       <= frac_carry ? '0 : frac_sum[FRAC_W-1:0];
                        if (frac_carry) begin
                            exp_q <= exp_q + E_W'(1);
                        end
                        round_step_q <= 1'b1;
                    end else begin
                        out_q        <= result_c;
                        ready_q      <= 1'b1;
                        round_step_q <= 1'b0;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out_Out   = out_q;
    assign bus.out_Ready = ready_q;

endmodule

// File: tb/tb_mod_divide.sv
// Self-checking bench for mod_divide: directed vectors, special cases,
// handshake behaviour, mid-operation reset and randomized operands checked
// against an arithmetic reference quotient.
module tb_mod_divide;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mod_divide_if #(.WORD_W(16)) bus ();

    mod_divide u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: exact integer quotient, then round-to-nearest-even
    function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, fa, fb, e, ma, mb, num, q, r, s, low, half, mant;
        bit sg, an, bn, ai, bi, az, bz, up;
        sg = a[15] ^ b[15];
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
        ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
        az = (ea == 0);               bz = (eb == 0);
        if (an || bn || (az && bz) || (ai && bi)) return 16'h7E00;
        if (ai || bz) return {sg, 5'h1F, 10'h000};
        if (az || bi) return {sg, 15'h0000};
        ma = 1024 + fa;
        mb = 1024 + fb;
        e  = ea - eb + 15;
        num = ma << 13;
        q = num / mb;
        r = num % mb;
        if (q >= 8192) s = 3;
        else begin
            s = 2;
            e = e - 1;
        end
        mant = q >> s;
        low  = q & ((1 << s) - 1);
        half = 1 << (s - 1);
        up   = (low > half) || ((low == half) && ((r != 0) || ((mant % 2) == 1)));
        mant = mant + int'(up);
        if (mant == 2048) begin
            mant = 1024;
            e = e + 1;
        end
        if (e >= 31) return {sg, 5'h1F, 10'h000};
        if (e <= 0) return {sg, 15'h0000};
        return {sg, 5'(e), 10'(mant - 1024)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one divide from IDLE and wait (bounded) for the ready pulse.
    // lat = edges after the capture edge; 0 means no pulse arrived.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output int lat);
        bus.in_A  = a;
        bus.in_B  = b;
        bus.in_En = 1'b1;
        step();
        bus.in_En = 1'b0;
        res = 16'hxxxx;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.out_Ready === 1'b1) begin
                lat = k;
                res = bus.out_Out;
                break;
            end
        end
        if (lat != 0) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_En = 1'b0;
        bus.in_A = 16'h0000;
        bus.in_B = 16'h0000;
        repeat (3) step();
        checks++;
        if (bus.out_Out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out: got %h want 0000", bus.out_Out);
        end
        checks++;
        if (bus.out_Ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", bus.out_Ready);
        end
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (bus.out_Ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b want 0", bus.out_Ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [12] = '{16'h57B7, 16'h4600, 16'h3C00, 16'h3C00, 16'h8000, 16'h7C00,
                                 16'h7E00, 16'h3C00, 16'h7BFF, 16'h0400, 16'h7C00, 16'h0000};
        logic [15:0] tb [12] = '{16'hD7B7, 16'h4000, 16'h4200, 16'h0000, 16'h0000, 16'h7C00,
                                 16'h3C00, 16'hFC00, 16'h3800, 16'h4000, 16'hC000, 16'h4000};
        logic [15:0] te [12] = '{16'hBC00, 16'h4200, 16'h3555, 16'h7C00, 16'h7E00, 16'h7E00,
                                 16'h7E00, 16'h8000, 16'h7C00, 16'h0000, 16'hFC00, 16'h0000};
        logic [15:0] res;
        int lat;
        for (int i = 0; i < 12; i++) begin
            run_div(ta[i], tb[i], res, lat);
            checks++;
            if (res !== te[i]) begin
                errors++;
                $display("FAIL directed_%0d %h/%h: got %h want %h", i, ta[i], tb[i], res, te[i]);
            end
            checks++;
            if (lat != 15) begin
                errors++;
                $display("FAIL latency_%0d: got %0d want 15", i, lat);
            end
            checks++;
            if (bus.out_Ready !== 1'b0 || bus.out_Out !== te[i]) begin
                errors++;
                $display("FAIL hold_%0d: ready %b out %h want 0 %h", i, bus.out_Ready, bus.out_Out, te[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, res, want;
        int lat;
        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            // Keep exponents close on half the trials so normal results dominate
            if (i % 2 == 0) begin
                a[14:10] = 5'($urandom_range(10, 20));
                b[14:10] = 5'($urandom_range(10, 20));
            end
            want = ref_div(a, b);
            run_div(a, b, res, lat);
            checks++;
            if (res !== want || lat != 15) begin
                errors++;
                $display("FAIL random_%0d %h/%h: got %h lat %0d want %h lat 15", i, a, b, res, lat, want);
            end
        end
    endtask

    task automatic test_ignore_en();
        logic [15:0] res;
        int lat = 0;
        int pulses = 0;
        bus.in_A  = 16'h4600;
        bus.in_B  = 16'h4000;
        bus.in_En = 1'b1;
        step();
        bus.in_En = 1'b0;
        repeat (4) step();
        bus.in_A  = 16'h3C00;
        bus.in_B  = 16'h4200;
        bus.in_En = 1'b1;
        step();
        bus.in_En = 1'b0;
        res = 16'hxxxx;
        for (int k = 6; k <= 40; k++) begin
            step();
            if (bus.out_Ready === 1'b1) begin
                lat = k;
                res = bus.out_Out;
                break;
            end
        end
        checks++;
        if (res !== 16'h4200 || lat != 15) begin
            errors++;
            $display("FAIL ignore_en: got %h lat %0d want 4200 lat 15", res, lat);
        end
        for (int k = 0; k < 25; k++) begin
            step();
            if (bus.out_Ready === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL ignore_en_extra: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int idx [$];
        logic [15:0] vals [$];
        bus.in_A  = 16'h3C00;
        bus.in_B  = 16'h4200;
        bus.in_En = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            step();
            if (bus.out_Ready === 1'b1) begin
                idx.push_back(e);
                vals.push_back(bus.out_Out);
            end
        end
        bus.in_En = 1'b0;
        repeat (20) step();
        checks++;
        if (idx.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", idx.size());
        end else begin
            checks++;
            if (idx[0] != 16) begin
                errors++;
                $display("FAIL b2b_first: got edge %0d want 16", idx[0]);
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (idx[i] - idx[i-1] != 17) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: got %0d want 17", i, idx[i] - idx[i-1]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (vals[i] !== 16'h3555) begin
                    errors++;
                    $display("FAIL b2b_value_%0d: got %h want 3555", i, vals[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] res;
        int lat;
        int pulses = 0;
        bus.in_A  = 16'h4600;
        bus.in_B  = 16'h4000;
        bus.in_En = 1'b1;
        step();
        bus.in_En = 1'b0;
        repeat (7) step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.out_Out !== 16'h0000 || bus.out_Ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out %h ready %b want 0000 0", bus.out_Out, bus.out_Ready);
        end
        rst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            step();
            if (bus.out_Ready === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL mid_reset_pulse: got %0d pulses want 0", pulses);
        end
        run_div(16'h3C00, 16'h4200, res, lat);
        checks++;
        if (res !== 16'h3555 || lat != 15) begin
            errors++;
            $display("FAIL after_reset: got %h lat %0d want 3555 lat 15", res, lat);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_En = 1'b0;
        bus.in_A  = 16'h0000;
        bus.in_B  = 16'h0000;
        rst       = 1'b0;
        test_reset();
        test_directed();
        test_ignore_en();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
